// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: board size defaults, stepper states,
// cell indexing helper and the glider seed image used at reset.
package gol_pkg;

    localparam int GOL_WIDTH  = 10;
    localparam int GOL_HEIGHT = 9;
    localparam int GOL_CELLS  = GOL_WIDTH * GOL_HEIGHT;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    // Row-major bit position of a cell
    function automatic int cell_idx(input int row, input int col, input int width);
        return row * width + col;
    endfunction

    // Glider: (6,6), (7,7), (8,5), (8,6), (8,7)
    localparam logic [GOL_CELLS-1:0] GOL_GLIDER =
        (90'b1 << 66) | (90'b1 << 77) | (90'b1 << 85) |
        (90'b1 << 86) | (90'b1 << 87);

endpackage

// File: rtl/gol_rule.sv
// Conway rule for one cell: birth on 3 neighbours, survival on 2 or 3.
// Purely combinational.
module gol_rule (
    input  logic       centre,
    input  logic [7:0] nbrs,
    output logic       next
);

    logic [3:0] cnt;

    // Count live neighbours and apply the rule
    always_comb begin
        cnt  = 4'($countones(nbrs));
        next = (cnt == 4'd3) || (centre && (cnt == 4'd2));
    end

endmodule

// File: rtl/gol_stepper.sv
// Game-of-Life generation stepper: scans the committed board one cell per
// clock into a shadow buffer, then commits the whole generation at once.
module gol_stepper
    import gol_pkg::*;
#(
    parameter int WIDTH  = GOL_WIDTH,
    parameter int HEIGHT = GOL_HEIGHT,
    parameter bit WRAP   = 1'b0,
    parameter logic [WIDTH*HEIGHT-1:0] INIT = GOL_GLIDER
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic                    load_en,
    input  logic [3:0]              load_row,
    input  logic [WIDTH-1:0]        load_data,
    output logic [WIDTH*HEIGHT-1:0] board,
    output logic                    busy,
    output logic                    done,
    output logic [9:0]              gen
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    state_t          state, next_state;
    logic [N-1:0]    shadow;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [IW-1:0]   cur;
    logic [7:0]      nbrs;
    logic            centre;
    logic            nxt;
    logic            last;
    logic            load_ok;

    assign cur     = IW'(cell_idx(int'(row), int'(col), WIDTH));
    assign centre  = board[cur];
    assign last    = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
    assign load_ok = int'(load_row) < HEIGHT;

    // Gather the 8 neighbours of the scan position from the committed board
    always_comb begin
        int rr;
        int cc;
        int k;
        rr   = 0;
        cc   = 0;
        k    = 0;
        nbrs = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    rr = int'(row) + dr;
                    cc = int'(col) + dc;
                    if (WRAP) begin
                        if (rr < 0)       rr = rr + HEIGHT;
                        if (rr >= HEIGHT) rr = rr - HEIGHT;
                        if (cc < 0)       cc = cc + WIDTH;
                        if (cc >= WIDTH)  cc = cc - WIDTH;
                    end
                    if (rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH)
                        nbrs[3'(k)] = board[IW'(cell_idx(rr, cc, WIDTH))];
                    k = k + 1;
                end
            end
        end
    end

    gol_rule u_rule (
        .centre (centre),
        .nbrs   (nbrs),
        .next   (nxt)
    );

    // Next-state: loads win over step in idle; scan ends on the last cell
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!load_en && step) next_state = SCAN;
            SCAN:    if (last) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, scan counters, shadow buffer, board and generation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            board  <= INIT;
            shadow <= '0;
            gen    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (state == COMMIT);
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        if (load_ok)
                            board[IW'(int'(load_row) * WIDTH) +: WIDTH] <= load_data;
                    end else if (step) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                SCAN: begin
                    shadow[cur] <= nxt;
                    if (col == CW'(WIDTH - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                COMMIT: begin
                    board <= shadow;
                    gen   <= gen + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_stepper.sv
// Directed bench for gol_stepper: one non-wrapping and one toroidal instance
// driven by the same stimulus, checked against hand-computed boards.
module tb_gol_stepper;
    import gol_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        load_en;
    logic [3:0]  load_row;
    logic [9:0]  load_data;
    logic [89:0] board0, board1;
    logic        busy0, busy1, done0, done1;
    logic [9:0]  gen0, gen1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gol_stepper #(.WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .step(step), .load_en(load_en),
        .load_row(load_row), .load_data(load_data),
        .board(board0), .busy(busy0), .done(done0), .gen(gen0)
    );

    gol_stepper #(.WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .step(step), .load_en(load_en),
        .load_row(load_row), .load_data(load_data),
        .board(board1), .busy(busy1), .done(done1), .gen(gen1)
    );

    task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] r, input logic [9:0] d);
        load_en   = 1'b1;
        load_row  = r;
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic do_step();
        int n;
        n    = 0;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        while (!done0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("step_done_seen", 90'(done0), 90'(1'b1));
    endtask

    initial begin
        logic [89:0] exp;
        int          done_cnt;
        int          done_at;
        logic        b92;

        rst = 1'b1; step = 1'b0; load_en = 1'b0;
        load_row = '0; load_data = '0;
        do_reset();

        // reset state
        chk("rst_board", board0, GOL_GLIDER);
        chk("rst_gen", 90'(gen0), 90'd0);
        chk("rst_busy", 90'(busy0), 90'd0);
        chk("rst_done", 90'(done0), 90'd0);

        // timing of one generation
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        chk("busy_cycle1", 90'(busy0), 90'd1);
        done_cnt = done0 ? 1 : 0;
        done_at  = done0 ? 1 : 0;
        b92      = 1'b1;
        for (int c = 2; c <= 92; c++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (c == 92) b92 = busy0;
        end
        chk("done_count", 90'(done_cnt), 90'd1);
        chk("done_cycle", 90'(done_at), 90'd92);
        chk("busy_cycle92", 90'(b92), 90'd0);
        chk("gen_after_1", 90'(gen0), 90'd1);

        // toroidal glider after 4 generations
        do_step();
        do_step();
        do_step();
        exp = '0;
        exp[77] = 1'b1; exp[88] = 1'b1;
        exp[6]  = 1'b1; exp[7]  = 1'b1; exp[8] = 1'b1;
        chk("glider_wrap", board1, exp);
        chk("glider_gen", 90'(gen1), 90'd4);

        // still-life block at the corner
        do_reset();
        for (int r = 0; r < 9; r++) load(4'(r), (r < 2) ? 10'b11 : 10'b0);
        do_step();
        exp = '0;
        exp[0] = 1'b1; exp[1] = 1'b1; exp[10] = 1'b1; exp[11] = 1'b1;
        chk("block_nowrap", board0, exp);
        chk("block_wrap", board1, exp);

        // block plus a corner cell that touches it only through the wrap
        load(4'd8, 10'h200);
        do_step();
        chk("block_corner_nowrap", board0, exp);
        exp = '0;
        exp[1] = 1'b1; exp[10] = 1'b1; exp[11] = 1'b1;
        exp[9] = 1'b1; exp[80] = 1'b1;
        chk("block_corner_wrap", board1, exp);
        chk("corner_dead_wrap", 90'(board1[89]), 90'd0);

        // blinker
        do_reset();
        for (int r = 0; r < 9; r++) load(4'(r), (r == 4) ? 10'b0000111000 : 10'b0);
        do_step();
        exp = '0;
        exp[34] = 1'b1; exp[44] = 1'b1; exp[54] = 1'b1;
        chk("blinker_vert", board0, exp);
        do_step();
        exp = '0;
        exp[43] = 1'b1; exp[44] = 1'b1; exp[45] = 1'b1;
        chk("blinker_horiz", board0, exp);
        chk("blinker_gen", 90'(gen0), 90'd2);

        // step and load during SCAN are ignored
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        step = 1'b1; load_en = 1'b1; load_row = 4'd0; load_data = 10'h3FF;
        repeat (3) @(posedge clk);
        #1;
        step = 1'b0; load_en = 1'b0;
        done_cnt = 0;
        while (!done0 && done_cnt < 300) begin
            @(posedge clk);
            #1;
            done_cnt++;
        end
        exp = '0;
        exp[34] = 1'b1; exp[44] = 1'b1; exp[54] = 1'b1;
        chk("scan_ignore_board", board0, exp);
        chk("scan_ignore_gen", 90'(gen0), 90'd3);
        @(posedge clk);
        #1;
        chk("scan_step_not_queued", 90'(busy0), 90'd0);

        // load has priority over step in idle
        step = 1'b1;
        load(4'd0, 10'h3FF);
        step = 1'b0;
        chk("load_step_busy", 90'(busy0), 90'd0);
        exp[9:0] = 10'h3FF;
        chk("load_step_board", board0, exp);

        // out-of-range row is ignored
        load(4'd12, 10'h155);
        chk("load_row_oob", board0, exp);

        // reset in the middle of a scan
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (39) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_board", board0, GOL_GLIDER);
        chk("midrst_busy", 90'(busy0), 90'd0);
        chk("midrst_gen", 90'(gen0), 90'd0);
        #10 rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) done_cnt++;
        end
        chk("midrst_no_done", 90'(done_cnt), 90'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
